// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_sequencer: command/response front end for the 8-bit combinational ALU   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_chain,
  input  logic             acc_clr,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_div0,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   is_div0;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign is_div0   = (cmd_op == OP_DIV) && (cmd_b == 8'h00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_div0 ? RESP : ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_sel   <= 4'h0;
      rsp_data  <= 8'h00;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_div0  <= 1'b0;
      acc       <= 8'h00;
      op_count  <= '0;
    end else begin
      if (accept) begin
        alu_sel <= cmd_op;
        alu_b   <= cmd_b;
        alu_a   <= cmd_chain ? (acc_clr ? 8'h00 : acc) : cmd_a;
        // Divide-by-zero is answered directly; the ALU result is never captured.
        if (is_div0) begin
          rsp_data  <= 8'hFF;
          rsp_carry <= 1'b0;
          rsp_zero  <= 1'b0;
          rsp_div0  <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        rsp_data  <= alu_out;
        rsp_carry <= (alu_sel == OP_ADD) && alu_carry;
        rsp_zero  <= (alu_out == 8'h00);
        rsp_div0  <= 1'b0;
      end
      if (acc_clr)
        acc <= 8'h00;
      else if (state == ISSUE)
        acc <= alu_out;
      if ((state == RESP) && rsp_ready)
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_sequencer: randomized self-checking bench with behavioural model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_sequencer;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_op;
  logic [7:0]          cmd_a;
  logic [7:0]          cmd_b;
  logic                cmd_chain;
  logic                acc_clr;
  logic [7:0]          alu_a;
  logic [7:0]          alu_b;
  logic [3:0]          alu_sel;
  logic [7:0]          alu_out;
  logic                alu_carry;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [7:0]          rsp_data;
  logic                rsp_carry;
  logic                rsp_zero;
  logic                rsp_div0;
  logic [7:0]          acc;
  logic [TB_CNT_W-1:0] op_count;

  alu_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_div0(rsp_div0),
    .acc(acc), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {add carry, result}; the add carry is presented for every op.
  function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'h0: r = s[7:0];
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: r = {a[6:0], 1'b0};
      4'h9: r = {1'b0, a[7:1]};
      4'hA: r = {a[6:0], a[7]};
      4'hB: r = {a[0], a[7:1]};
      4'hC: r = (b == 8'h00) ? 8'h00 : a % b;
      4'hD: r = {7'd0, a > b};
      4'hE: r = {7'd0, a < b};
      default: r = {7'd0, a == b};
    endcase
    return {s[8], r};
  endfunction

  always_comb {alu_carry, alu_out} = ref_alu(alu_sel, alu_a, alu_b);

  int vectors = 0;
  int errors  = 0;

  // Model state, updated by the driver just after each clock edge.
  logic [7:0]          m_acc;
  logic [TB_CNT_W-1:0] m_count;
  logic                exp_valid, exp_cmd_ready;
  logic [7:0]          exp_alu_a, exp_alu_b;
  logic [3:0]          exp_alu_sel;
  logic [7:0]          exp_data;
  logic                exp_carry, exp_zero, exp_div0;

  logic [7:0] got_data, got_alu_a;
  logic       got_carry, got_zero, got_div0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_count = '0;
    exp_valid = 1'b0; exp_cmd_ready = 1'b1;
    exp_alu_a = 8'h00; exp_alu_b = 8'h00; exp_alu_sel = 4'h0;
    exp_data = 8'h00; exp_carry = 1'b0; exp_zero = 1'b0; exp_div0 = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    chk("acc",       32'(acc),       32'(m_acc));
    chk("op_count",  32'(op_count),  32'(m_count));
    chk("alu_a",     32'(alu_a),     32'(exp_alu_a));
    chk("alu_b",     32'(alu_b),     32'(exp_alu_b));
    chk("alu_sel",   32'(alu_sel),   32'(exp_alu_sel));
    if (exp_valid || !rst_n) begin
      chk("rsp_data",  32'(rsp_data),  32'(exp_data));
      chk("rsp_carry", 32'(rsp_carry), 32'(exp_carry));
      chk("rsp_zero",  32'(rsp_zero),  32'(exp_zero));
      chk("rsp_div0",  32'(rsp_div0),  32'(exp_div0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random traffic on inputs the DUT must ignore outside IDLE, plus stray clears.
  task automatic noise(input bit rnd);
    if (rnd) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 4'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_chain = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 7) == 0);
      step();
      if (acc_clr) m_acc = 8'h00;
      acc_clr = 1'b0; rsp_ready = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, input logic clr, input int stall, input bit rnd);
    logic [7:0] eff_a;
    logic [8:0] r;
    logic       div0;
    eff_a = chain ? (clr ? 8'h00 : m_acc) : a;
    div0  = (op == 4'h3) && (b == 8'h00);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; acc_clr = clr;
    step();
    cmd_valid = 1'b0; acc_clr = 1'b0;
    if (clr) m_acc = 8'h00;
    exp_alu_a = eff_a; exp_alu_b = b; exp_alu_sel = op; exp_cmd_ready = 1'b0;
    got_alu_a = alu_a;
    if (div0) begin
      exp_data = 8'hFF; exp_carry = 1'b0; exp_zero = 1'b0; exp_div0 = 1'b1; exp_valid = 1'b1;
    end else begin
      noise(rnd);
      step();
      r = ref_alu(op, eff_a, b);
      exp_data  = r[7:0];
      exp_carry = (op == 4'h0) ? r[8] : 1'b0;
      exp_zero  = (r[7:0] == 8'h00);
      exp_div0  = 1'b0;
      exp_valid = 1'b1;
      m_acc     = acc_clr ? 8'h00 : r[7:0];
      acc_clr = 1'b0; cmd_valid = 1'b0;
    end
    for (int i = 0; i < stall; i++) begin
      noise(rnd);
      rsp_ready = 1'b0;
      step();
      if (acc_clr) m_acc = 8'h00;
      acc_clr = 1'b0; cmd_valid = 1'b0;
    end
    noise(rnd);
    rsp_ready = 1'b1;
    got_data = rsp_data; got_carry = rsp_carry; got_zero = rsp_zero; got_div0 = rsp_div0;
    step();
    if (acc_clr) m_acc = 8'h00;
    acc_clr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    m_count   = m_count + TB_CNT_W'(1);
    exp_valid = 1'b0; exp_cmd_ready = 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] b;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_chain = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_op_count", 32'(op_count), 32'd0);

    run_cmd(4'h0, 8'd200, 8'd100, 1'b0, 1'b0, 0, 1'b0);
    chk("add_data", 32'(got_data), 32'd44);
    chk("add_carry", 32'(got_carry), 32'd1);
    chk("add_zero", 32'(got_zero), 32'd0);
    chk("add_count", 32'(op_count), 32'd1);

    run_cmd(4'h0, 8'd5, 8'd3, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(4'h2, 8'd0, 8'd4, 1'b1, 1'b0, 0, 1'b0);
    chk("chain_data", 32'(got_data), 32'd32);
    chk("chain_carry", 32'(got_carry), 32'd0);
    chk("chain_acc", 32'(acc), 32'd32);

    run_cmd(4'h3, 8'd9, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    chk("div0_data", 32'(got_data), 32'hFF);
    chk("div0_flag", 32'(got_div0), 32'd1);
    chk("div0_acc", 32'(acc), 32'd32);

    run_cmd(4'hF, 8'd7, 8'd7, 1'b0, 1'b0, 5, 1'b0);
    chk("bp_data", 32'(got_data), 32'd1);
    chk("bp_zero", 32'(got_zero), 32'd0);

    run_cmd(4'h0, 8'd5, 8'd3, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(4'h2, 8'd0, 8'd4, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(4'h0, 8'd0, 8'd1, 1'b1, 1'b1, 0, 1'b0);
    chk("clr_alu_a", 32'(got_alu_a), 32'd0);
    chk("clr_data", 32'(got_data), 32'd1);

    // Reset asserted while the command sits in ISSUE.
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'd50; cmd_b = 8'd60; cmd_chain = 1'b0;
    step();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_cmd(4'h0, 8'd1, 8'd2, 1'b0, 1'b0, 0, 1'b0);
    chk("post_rst_data", 32'(got_data), 32'd3);
    chk("post_rst_count", 32'(op_count), 32'd1);

    for (int n = 0; n < 300; n++) begin
      idle($urandom_range(0, 2));
      op = 4'($urandom);
      b  = 8'($urandom);
      if ((op == 4'h3) && ($urandom_range(0, 2) == 0)) b = 8'h00;
      run_cmd(op, 8'($urandom), b, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b1);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
